// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing stages.
package sc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned INWD_DEF = 8;

  // Stream length in bits for a given operand width.
  function automatic int unsigned stream_len(input int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/sobol_sng_ctrl.sv
// Sobol-driven stochastic number generator: operand in, 2^INWD-bit unipolar stream out.
// Optional per-stream ones counter and sticky mismatch flag under SOBOL_SNG_ONES_CNT_EN.
module sobol_sng_ctrl
  import sc_pkg::*;
#(
  parameter int unsigned INWD = INWD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [INWD-1:0] in_data,
  input  logic [INWD-1:0] rng_seq,
  output logic            rng_enable,
  output logic            bit_out,
  output logic            bit_valid,
  input  logic            bit_ready,
  output logic            bit_last,
  output logic            busy
`ifdef SOBOL_SNG_ONES_CNT_EN
  ,
  output logic [INWD:0]   ones_cnt,
  output logic            cnt_err
`endif
);

  localparam int unsigned LEN = stream_len(INWD);
  localparam logic [INWD-1:0] CNT_MAX = INWD'(LEN - 1);

  state_t          state;
  state_t          state_nxt;
  logic [INWD-1:0] operand;
  logic [INWD-1:0] cnt;
  logic            adv;
  logic            step;
  logic            last_step;
  logic            accept;

  // A step is possible whenever the output register is empty or draining.
  assign adv       = ~bit_valid | bit_ready;
  assign step      = (state == RUN) && adv;
  assign last_step = step && (cnt == CNT_MAX);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (last_step) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    rng_enable = 1'b0;
    busy       = bit_valid;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        in_ready   = last_step;
        rng_enable = adv;
        busy       = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand, sample index and the registered output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand   <= '0;
      cnt       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
    end else begin
      if (step) begin
        bit_out   <= (rng_seq < operand);
        bit_valid <= 1'b1;
        bit_last  <= (cnt == CNT_MAX);
        cnt       <= cnt + INWD'(1);
      end else if ((state == IDLE) && bit_valid && bit_ready) begin
        bit_valid <= 1'b0;
        bit_last  <= 1'b0;
      end
      if (accept) begin
        operand <= in_data;
        cnt     <= '0;
      end
    end
  end

`ifdef SOBOL_SNG_ONES_CNT_EN
  localparam int unsigned OW = INWD + 1;

  logic            xfer;
  logic            first_bit;
  logic [INWD-1:0] stream_op;
  logic [OW-1:0]   ones_nxt;

  assign xfer = bit_valid && bit_ready;

  // Count restarts on the first transferred bit of each stream.
  always_comb begin
    ones_nxt = (first_bit ? OW'(0) : ones_cnt) + OW'(bit_out);
  end

  // stream_op remembers the operand of the stream whose last bit is pending,
  // since a back-to-back handshake replaces operand before that bit drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt  <= '0;
      cnt_err   <= 1'b0;
      first_bit <= 1'b1;
      stream_op <= '0;
    end else begin
      if (last_step) stream_op <= operand;
      if (xfer) begin
        ones_cnt  <= ones_nxt;
        first_bit <= bit_last;
        if (bit_last && (ones_nxt != OW'(stream_op))) cnt_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/sobol_sng_ctrl.md
Name: sobol_sng_ctrl

Overview:
- Stochastic number generator stage that sits directly downstream of the dimension-1 Sobol RNG.
- Accepts a binary operand over a valid/ready handshake and drives the RNG's enable.
- Compares each RNG sample against the operand and emits a unipolar bitstream of exactly 2^INWD bits, with last-bit marking and downstream backpressure.
- Over one full period the number of ones equals the operand exactly.

Parameters:
- INWD, 8, operand/RNG width; stream length is 2^INWD bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid && in_ready
- in_data  in  INWD  unsigned operand, value/2^INWD
- rng_seq  in  INWD  current Sobol sample from the RNG
- rng_enable  out  1  advance RNG; wired to the RNG enable
- bit_out  out  1  stochastic bit
- bit_valid  out  1  bit_out valid
- bit_ready  in  1  downstream accepts bit when bit_valid && bit_ready
- bit_last  out  1  marks the final (2^INWD-th) bit of a stream
- busy  out  1  stream in progress or output register occupied

Behaviour:
- Reset (async): state=IDLE, operand=0, cnt=0, bit_out=0, bit_valid=0, bit_last=0, rng_enable=0.
- The RNG shares rst_n, so a mid-stream reset restarts both blocks coherently.
- States: IDLE, RUN.
  - IDLE: in_ready=1, rng_enable=0. On handshake: operand<=in_data, cnt<=0, go to RUN.
  - RUN: a step occurs when adv = (~bit_valid || bit_ready).
    - rng_enable = adv, combinational.
    - On a step: bit_out <= (rng_seq < operand), unsigned compare; bit_valid <= 1; bit_last <= (cnt == 2^INWD-1); cnt <= cnt+1.
  - When not stepping, all registers hold and the RNG is frozen.
- Leaving RUN:
  - The step with cnt == 2^INWD-1 returns to IDLE; cnt wraps to 0.
  - in_ready is also 1 during that final step, giving zero-bubble back-to-back streams.
  - If a handshake occurs in that final step: the new operand loads, cnt=0, state stays RUN.
- Output register:
  - In IDLE with bit_valid && bit_ready and no new step: bit_valid <= 0 and bit_last <= 0.
- Latency: the first bit is valid 2 cycles after the operand handshake, 1 cycle after the first RUN cycle.
- Throughput: 1 bit/cycle with bit_ready held high.
- Exactness: the RNG index counter wraps at 2^INWD, so any 2^INWD consecutive enabled samples are a permutation of 0..2^INWD-1. Ones count = operand for any starting RNG phase.
- Boundaries:
  - operand=0 gives all zeros.
  - operand=2^INWD-1 gives exactly one zero.
  - The operand register is never modified during RUN except on the final-step handshake.
- busy = (state==RUN) || bit_valid.

Optional Feature:
- Macro: SOBOL_SNG_ONES_CNT_EN.
- When defined:
  - Adds outputs ones_cnt [INWD:0] and cnt_err [1].
  - ones_cnt accumulates accepted ones per stream and clears at stream start.
  - ones_cnt is stable from the cycle after the bit_last transfer until the next stream's first bit transfer.
  - cnt_err is a sticky flag, set if the final count != operand; cleared only by reset.
- When undefined: those ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sc_pkg:
  - state typedef enum {IDLE, RUN};
  - default INWD constant;
  - localparam function for stream length 2^INWD.
- No sub-module is needed. The comparator is inline. An optional ones counter may be a sub-module sc_ones_cnt, reusable by the bitstream-to-binary stage.

Test Plan:
- INWD=3, operand 5, bit_ready=1 -> 8 bits with the Sobol dim1 RNG; exactly 5 ones; bit_last on the 8th; first bit_valid 2 cycles after handshake; in_ready low cycles 2-8.
- Back-to-back operands 3 then 6, in_valid held -> second handshake in the final step; 16 contiguous valid bits; ones 3 and 6; no bubble.
- Operand 0 and operand 7 (INWD=3) -> 0 ones and 7 ones respectively.
- bit_ready toggling randomly, operand 4 -> rng_enable low whenever the output is held; bit_out/bit_last stable while stalled; total ones 4, 8 bits transferred.
- Assert rst_n low at bit 4 of a stream -> all outputs 0 asynchronously; IDLE with in_ready=1; new operand 2 yields a correct 2-ones stream.
- SOBOL_SNG_ONES_CNT_EN, INWD=8, 100 random operands -> ones_cnt == operand each stream; cnt_err stays 0.
